factor_game_ctrl: RTL
=====================

# factor_game_ctrl

Game sequencer for the factorization board. It generates a target number as the product of three hidden factors (2..9) and presents it on TARGET. It waits for the player to confirm three entered digits through the digit-entry block's DEC/COUNTx_out path, then judges whether their product equals the target. It drives the STATE and RESULT codes that the digit-entry and display logic consume, and keeps score, lives and round count across a game.

## Interface
- SEED, 9'h1FF: non-zero LFSR seed, loaded on reset
- ROUNDS, 5: rounds per game (1..15)
- SHOW_CYCLES, 50_000_000: cycles RESULT is held after a judgement (>=1)

- CLK  in  1  clock; one clock domain
- RST  in  1  reset, synchronous, active-high
- START  in  1  level button; rising edge starts or restarts a game
- DEC  in  1  level confirm button, shared with the digit-entry block
- COUNT1_in, COUNT2_in, COUNT3_in  in  4 each  latched digits from the digit-entry block (COUNTx_out), 0..9
- STATE  out  4  0 IDLE, 1 GEN, 2 INPUT, 3 CHECK, 4 SHOW, 5 OVER
- RESULT  out  2  00 none, 01 wrong, 11 correct
- TARGET  out  10  current target, 8..729
- SCORE  out  4  correct answers, saturates at 15
- LIVES  out  2  remaining lives
- ROUND  out  4  completed rounds in the current game

## Operation
- Reset values: STATE=0, RESULT=00, TARGET=0, SCORE=0, LIVES=3, ROUND=0, LFSR=SEED, START_d=DEC_d=0, all FSM substates and counters cleared. RST has priority in every state, including mid-CHECK and mid-SHOW.
- Edge detect: START_d and DEC_d are registered copies of the inputs. An edge is `X & ~X_d`. Holding a button high produces exactly one edge.
- IDLE: on a START edge, go to GEN.
- GEN, 2 cycles:
  - G1 latches f0=LFSR[2:0]+2, f1=LFSR[5:3]+2, f2=LFSR[8:6]+2, registers f0*f1 (7 bits), then steps the LFSR once.
  - G2 writes TARGET=(f0*f1)*f2 (10 bits, no overflow), then goes to INPUT.
- LFSR step: LFSR <= {LFSR[7:0], LFSR[8]^LFSR[4]}. It advances only in G1, so the target sequence depends only on SEED.
- INPUT: wait for a DEC edge, then go to CHECK. DEC edges in any other state are ignored, but DEC_d still updates.
- CHECK, 2 cycles:
  - C1 samples COUNT1_in..COUNT3_in and registers p=COUNT1_in*COUNT2_in (7 bits) and c3.
  - C2 compares p*c3 (10 bits) with TARGET.
  - Equal: RESULT=11, SCORE+1 (saturating).
  - Not equal: RESULT=01, LIVES-1.
  - In both cases ROUND+1. A zero digit always judges wrong.
- SHOW: hold RESULT for SHOW_CYCLES cycles, then RESULT=00.
  - If LIVES==0 or ROUND==ROUNDS, go to OVER.
  - Otherwise go to GEN.
- OVER: TARGET, SCORE, LIVES and ROUND hold their values.
  - A START edge sets SCORE=0, LIVES=3, ROUND=0 and goes to GEN.
  - The LFSR is not reseeded.
- START edges in GEN, INPUT, CHECK and SHOW are ignored.

## Timing
- All outputs are registered. STATE changes on the edge that sampled the triggering condition.
- START edge sampled at edge n: STATE=1 after n. TARGET valid and STATE=2 after n+2.
- DEC edge sampled at edge m: STATE=3 after m. COUNTx_in is sampled at m+1, which gives the digit-entry block one cycle to update COUNTx_out. RESULT, SCORE, LIVES and ROUND update at m+2, where STATE becomes 4.
- RESULT is non-zero for exactly SHOW_CYCLES+1 cycles: from edge m+2 through the SHOW-exit edge.
- A DEC press in INPUT yields a judgement 2 cycles later, plus SHOW_CYCLES.
- The SHOW counter needs ceil(log2(SHOW_CYCLES+1)) bits.

## Test plan
All scenarios use SEED=9'h1FF and SHOW_CYCLES=4.
- Reset/start: assert RST for 2 cycles -> all outputs at their reset values. START pulse -> STATE 1, then 2, with TARGET=729 two cycles after the edge.
- Correct path (ROUNDS=2):
  - Enter 9,9,9 and pulse DEC -> RESULT=11 and SCORE=1 two cycles after the edge. RESULT holds 5 cycles, then STATE=1.
  - Next TARGET=648. Enter 9,8,9 -> RESULT=11, SCORE=2, then STATE=5 with ROUND=2.
- Wrong and lives (ROUNDS=5): enter 0,9,9 on round 1 -> RESULT=01, LIVES=2. Three wrong rounds (targets 729, 648, 486) -> LIVES=0, STATE=5, ROUND=3.
- DEC discipline:
  - Hold DEC high for 20 cycles in INPUT -> exactly one judgement.
  - DEC edges during GEN/SHOW -> no state change.
  - START during INPUT -> ignored.
- Restart from OVER: START edge -> SCORE=0, LIVES=3, ROUND=0. TARGET continues the LFSR sequence instead of returning to 729.
- Reset mid-operation: assert RST during C2 and again during SHOW -> next cycle STATE=0, RESULT=00, SCORE/LIVES unchanged from their reset values. The next START gives TARGET=729.

Source files
------------

// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: factorization board game sequencer.
// Builds a 3-factor target, judges the player's digits, keeps score/lives.
module factor_game_ctrl #(
  parameter logic [8:0] SEED        = 9'h1FF,
  parameter int         ROUNDS      = 5,
  parameter int         SHOW_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       DEC,
  input  logic [3:0] COUNT1_in,
  input  logic [3:0] COUNT2_in,
  input  logic [3:0] COUNT3_in,
  output logic [3:0] STATE,
  output logic [1:0] RESULT,
  output logic [9:0] TARGET,
  output logic [3:0] SCORE,
  output logic [1:0] LIVES,
  output logic [3:0] ROUND
);

  localparam int CW = $clog2(SHOW_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GEN   = 3'd1,
    S_INPUT = 3'd2,
    S_CHECK = 3'd3,
    S_SHOW  = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_sub;
  logic   w_sub_nxt;

  logic          r_start_d;
  logic          r_dec_d;
  logic [8:0]    r_lfsr;
  logic [6:0]    r_f01;
  logic [3:0]    r_f2;
  logic [6:0]    r_p;
  logic [3:0]    r_c3;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_result;
  logic [9:0]    r_target;
  logic [3:0]    r_score;
  logic [1:0]    r_lives;
  logic [3:0]    r_round;

  logic       w_start_edge;
  logic       w_dec_edge;
  logic       w_g1;
  logic       w_g2;
  logic       w_c1;
  logic       w_c2;
  logic       w_show_exit;
  logic       w_new_game;
  logic [3:0] w_f0;
  logic [3:0] w_f1;
  logic [3:0] w_f2;
  logic [9:0] w_prod;
  logic       w_match;

  assign w_start_edge = START & ~r_start_d;
  assign w_dec_edge   = DEC & ~r_dec_d;

  // Factors are 3-bit LFSR fields offset into 2..9.
  assign w_f0 = {1'b0, r_lfsr[2:0]} + 4'd2;
  assign w_f1 = {1'b0, r_lfsr[5:3]} + 4'd2;
  assign w_f2 = {1'b0, r_lfsr[8:6]} + 4'd2;

  assign w_prod  = 10'(r_p) * 10'(r_c3);
  assign w_match = (w_prod == r_target);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_sub   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = r_sub;
    w_g1        = 1'b0;
    w_g2        = 1'b0;
    w_c1        = 1'b0;
    w_c2        = 1'b0;
    w_show_exit = 1'b0;
    w_new_game  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_edge) w_state_nxt = S_GEN;
      end
      S_GEN: begin
        if (!r_sub) begin
          w_g1      = 1'b1;
          w_sub_nxt = 1'b1;
        end else begin
          w_g2        = 1'b1;
          w_sub_nxt   = 1'b0;
          w_state_nxt = S_INPUT;
        end
      end
      S_INPUT: begin
        if (w_dec_edge) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!r_sub) begin
          w_c1      = 1'b1;
          w_sub_nxt = 1'b1;
        end else begin
          w_c2        = 1'b1;
          w_sub_nxt   = 1'b0;
          w_state_nxt = S_SHOW;
        end
      end
      S_SHOW: begin
        if (r_cnt == CW'(SHOW_CYCLES)) begin
          w_show_exit = 1'b1;
          if (r_lives == 2'd0 || r_round == 4'(ROUNDS))
            w_state_nxt = S_OVER;
          else
            w_state_nxt = S_GEN;
        end
      end
      S_OVER: begin
        if (w_start_edge) begin
          w_new_game  = 1'b1;
          w_state_nxt = S_GEN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_sub_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_start_d <= 1'b0;
      r_dec_d   <= 1'b0;
      r_lfsr    <= SEED;
      r_f01     <= '0;
      r_f2      <= '0;
      r_p       <= '0;
      r_c3      <= '0;
      r_cnt     <= '0;
      r_result  <= 2'b00;
      r_target  <= '0;
      r_score   <= '0;
      r_lives   <= 2'd3;
      r_round   <= '0;
    end else begin
      r_start_d <= START;
      r_dec_d   <= DEC;
      if (w_g1) begin
        r_f01  <= 7'(w_f0) * 7'(w_f1);
        r_f2   <= w_f2;
        r_lfsr <= {r_lfsr[7:0], r_lfsr[8] ^ r_lfsr[4]};
      end
      if (w_g2) r_target <= 10'(r_f01) * 10'(r_f2);
      if (w_c1) begin
        r_p  <= 7'(COUNT1_in) * 7'(COUNT2_in);
        r_c3 <= COUNT3_in;
      end
      if (w_c2) begin
        r_round <= r_round + 4'd1;
        if (w_match) begin
          r_result <= 2'b11;
          if (r_score != 4'hF) r_score <= r_score + 4'd1;
        end else begin
          r_result <= 2'b01;
          r_lives  <= r_lives - 2'd1;
        end
      end
      // The counter runs only while in SHOW and rewinds on exit.
      if (r_state == S_SHOW && !w_show_exit)
        r_cnt <= r_cnt + CW'(1);
      else
        r_cnt <= '0;
      if (w_show_exit) r_result <= 2'b00;
      if (w_new_game) begin
        r_score <= '0;
        r_lives <= 2'd3;
        r_round <= '0;
      end
    end
  end

  assign STATE  = {1'b0, r_state};
  assign RESULT = r_result;
  assign TARGET = r_target;
  assign SCORE  = r_score;
  assign LIVES  = r_lives;
  assign ROUND  = r_round;

endmodule
